// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI-style pattern generator.
//   pix_t      : one 8-bit colour component
//   pg_mode_e  : payload selection (ramp, colour bars, solid)
//   ycbcr_t    : one pixel as {Y, Cb, Cr}
//   BAR_YCBCR  : the eight colour-bar values, left to right
//   DEF_*      : default 1080p timing
package hdmi_pkg;

  typedef logic [7:0] pix_t;

  typedef enum logic [1:0] {
    PG_RAMP  = 2'd0,
    PG_BARS  = 2'd1,
    PG_SOLID = 2'd2
  } pg_mode_e;

  typedef struct packed {
    pix_t y;
    pix_t cb;
    pix_t cr;
  } ycbcr_t;

  localparam ycbcr_t BAR_YCBCR [8] = '{
    '{8'd235, 8'd128, 8'd128},
    '{8'd210, 8'd16,  8'd146},
    '{8'd170, 8'd166, 8'd16 },
    '{8'd145, 8'd54,  8'd34 },
    '{8'd106, 8'd202, 8'd222},
    '{8'd81,  8'd90,  8'd240},
    '{8'd41,  8'd240, 8'd110},
    '{8'd16,  8'd128, 8'd128}
  };

  localparam int DEF_N                   = 2;
  localparam int DEF_X_RES               = 1920;
  localparam int DEF_Y_RES               = 1080;
  localparam int DEF_H_SYNC_CYC          = 44;
  localparam int DEF_H_BACK_PORCH_CYC    = 148;
  localparam int DEF_H_FRONT_PORCH_CYC   = 88;
  localparam int DEF_V_SYNC_LINES        = 5;
  localparam int DEF_V_BACK_PORCH_LINES  = 36;
  localparam int DEF_V_FRONT_PORCH_LINES = 4;

endpackage

// File: rtl/hdmi_timing_cnt.sv
// Raster position counters and timing decode.
//   clk, rst_n      : clock, asynchronous active-low reset
//   adv             : advance the position by one clock (wraps at frame end)
//   last            : current position is the final clock of the frame
//   nxt_*           : sync / valid / frame_done decoded for the position the
//                     counters move to at this edge, so the parent can
//                     register them and have outputs aligned to the counters
//   nxt_bar         : colour-bar index of that position's beat
module hdmi_timing_cnt
  import hdmi_pkg::*;
#(
  parameter int N                   = DEF_N,
  parameter int X_RES               = DEF_X_RES,
  parameter int Y_RES               = DEF_Y_RES,
  parameter int H_SYNC_CYC          = DEF_H_SYNC_CYC,
  parameter int H_BACK_PORCH_CYC    = DEF_H_BACK_PORCH_CYC,
  parameter int H_FRONT_PORCH_CYC   = DEF_H_FRONT_PORCH_CYC,
  parameter int V_SYNC_LINES        = DEF_V_SYNC_LINES,
  parameter int V_BACK_PORCH_LINES  = DEF_V_BACK_PORCH_LINES,
  parameter int V_FRONT_PORCH_LINES = DEF_V_FRONT_PORCH_LINES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  output logic       last,
  output logic       nxt_h_sync,
  output logic       nxt_v_sync,
  output logic       nxt_valid,
  output logic       nxt_frame_done,
  output logic [2:0] nxt_bar
);

  localparam int H_ACT     = X_RES / N;
  localparam int H_A0      = H_SYNC_CYC + H_BACK_PORCH_CYC;
  localparam int H_TOT     = H_A0 + H_ACT + H_FRONT_PORCH_CYC;
  localparam int V_A0      = V_SYNC_LINES + V_BACK_PORCH_LINES;
  localparam int V_TOT     = V_A0 + Y_RES + V_FRONT_PORCH_LINES;
  localparam int H_W       = $clog2(H_TOT);
  localparam int V_W       = $clog2(V_TOT);
  // X_RES is a multiple of 8*N, so a bar spans whole beats
  localparam int BAR_BEATS = H_ACT / 8;

  typedef logic [H_W-1:0] h_t;
  typedef logic [V_W-1:0] v_t;

  localparam h_t H_LAST     = h_t'(H_TOT - 1);
  localparam h_t H_SYNC_END = h_t'(H_SYNC_CYC);
  localparam h_t H_ACT_BEG  = h_t'(H_A0);
  localparam h_t H_ACT_END  = h_t'(H_A0 + H_ACT);
  localparam h_t H_BAR_LEN  = h_t'(BAR_BEATS);
  localparam v_t V_LAST     = v_t'(V_TOT - 1);
  localparam v_t V_SYNC_END = v_t'(V_SYNC_LINES);
  localparam v_t V_ACT_BEG  = v_t'(V_A0);
  localparam v_t V_ACT_END  = v_t'(V_A0 + Y_RES);

  h_t h_cnt, h_nxt, beat;
  v_t v_cnt, v_nxt;

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (adv) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_nxt = h_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  assign last           = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign nxt_h_sync     = (h_nxt < H_SYNC_END);
  assign nxt_v_sync     = (v_nxt < V_SYNC_END);
  assign nxt_valid      = (v_nxt >= V_ACT_BEG) && (v_nxt < V_ACT_END) &&
                          (h_nxt >= H_ACT_BEG) && (h_nxt < H_ACT_END);
  assign nxt_frame_done = (h_nxt == H_LAST) && (v_nxt == V_LAST);
  // beat index within the line; only meaningful while nxt_valid
  assign beat           = h_nxt - H_ACT_BEG;
  assign nxt_bar        = 3'(beat / H_BAR_LEN);

endmodule

// File: rtl/hdmi_pattern_gen.sv
// HDMI-style raster source: CEA-like timing at N pixels per clock with a
// ramp, colour-bar or solid-colour payload.
//   clk, rst_n            : clock, asynchronous active-low reset
//   en                    : run request; sampled at frame start and frame end
//   i_mode                : 0 ramp, 1 colour bars, 2/3 solid
//   i_solid_y/cb/cr       : solid colour, latched at frame start
//   o_hdmi_v_sync/h_sync  : sync outputs
//   o_hdmi_data_valid     : active pixels present
//   o_hdmi_data_y/cr/cb   : lane i carries pixel N*beat+i
//   o_frame_done          : pulse on the last clock of a frame
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int N                   = DEF_N,
  parameter int X_RES               = DEF_X_RES,
  parameter int Y_RES               = DEF_Y_RES,
  parameter int H_SYNC_CYC          = DEF_H_SYNC_CYC,
  parameter int H_BACK_PORCH_CYC    = DEF_H_BACK_PORCH_CYC,
  parameter int H_FRONT_PORCH_CYC   = DEF_H_FRONT_PORCH_CYC,
  parameter int V_SYNC_LINES        = DEF_V_SYNC_LINES,
  parameter int V_BACK_PORCH_LINES  = DEF_V_BACK_PORCH_LINES,
  parameter int V_FRONT_PORCH_LINES = DEF_V_FRONT_PORCH_LINES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             i_mode,
  input  logic [7:0]             i_solid_y,
  input  logic [7:0]             i_solid_cb,
  input  logic [7:0]             i_solid_cr,
  output logic                   o_hdmi_v_sync,
  output logic                   o_hdmi_h_sync,
  output logic                   o_hdmi_data_valid,
  output logic signed [N-1:0][7:0] o_hdmi_data_y,
  output logic signed [N-1:0][7:0] o_hdmi_data_cr,
  output logic signed [N-1:0][7:0] o_hdmi_data_cb,
  output logic                   o_frame_done
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e   state;
  pg_mode_e mode_q, mode_in, mode_eff;
  pix_t     sy_q, scb_q, scr_q, sy_eff, scb_eff, scr_eff;
  pix_t     ramp_q, ramp_nxt;
  ycbcr_t   pix_nxt;
  logic     adv, last, start, stop, emit;
  logic     t_hs, t_vs, t_dv, t_fd;
  logic [2:0] t_bar;

  assign adv = (state == ST_RUN);

  hdmi_timing_cnt #(
    .N                   (N),
    .X_RES               (X_RES),
    .Y_RES               (Y_RES),
    .H_SYNC_CYC          (H_SYNC_CYC),
    .H_BACK_PORCH_CYC    (H_BACK_PORCH_CYC),
    .H_FRONT_PORCH_CYC   (H_FRONT_PORCH_CYC),
    .V_SYNC_LINES        (V_SYNC_LINES),
    .V_BACK_PORCH_LINES  (V_BACK_PORCH_LINES),
    .V_FRONT_PORCH_LINES (V_FRONT_PORCH_LINES)
  ) u_timing (
    .clk            (clk),
    .rst_n          (rst_n),
    .adv            (adv),
    .last           (last),
    .nxt_h_sync     (t_hs),
    .nxt_v_sync     (t_vs),
    .nxt_valid      (t_dv),
    .nxt_frame_done (t_fd),
    .nxt_bar        (t_bar)
  );

  // A frame starts from IDLE or back-to-back at the end of a frame; the
  // counters wrap to line 0 / clock 0 by themselves in the latter case.
  assign start = en && ((state == ST_IDLE) || last);
  assign stop  = (state == ST_RUN) && last && !en;
  assign emit  = start || ((state == ST_RUN) && !stop);

  always_comb begin
    case (i_mode)
      2'd0:    mode_in = PG_RAMP;
      2'd1:    mode_in = PG_BARS;
      default: mode_in = PG_SOLID;
    endcase
  end

  // At a start edge the freshly sampled inputs apply to the beat being built
  assign mode_eff = start ? mode_in    : mode_q;
  assign sy_eff   = start ? i_solid_y  : sy_q;
  assign scb_eff  = start ? i_solid_cb : scb_q;
  assign scr_eff  = start ? i_solid_cr : scr_q;
  assign ramp_nxt = ramp_q + 8'd1;

  // Every lane of a beat falls in the same bar, so one pixel value serves all lanes
  always_comb begin
    case (mode_eff)
      PG_RAMP: pix_nxt = {ramp_nxt, ramp_nxt, ramp_nxt};
      PG_BARS: pix_nxt = BAR_YCBCR[t_bar];
      default: pix_nxt = {sy_eff, scb_eff, scr_eff};
    endcase
  end

  // Output stage: FSM, mode latch and registered raster outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      mode_q            <= PG_RAMP;
      sy_q              <= '0;
      scb_q             <= '0;
      scr_q             <= '0;
      ramp_q            <= '0;
      o_hdmi_v_sync     <= 1'b0;
      o_hdmi_h_sync     <= 1'b0;
      o_hdmi_data_valid <= 1'b0;
      o_frame_done      <= 1'b0;
      o_hdmi_data_y     <= '0;
      o_hdmi_data_cb    <= '0;
      o_hdmi_data_cr    <= '0;
    end else begin
      if (start) begin
        state  <= ST_RUN;
        mode_q <= mode_in;
        sy_q   <= i_solid_y;
        scb_q  <= i_solid_cb;
        scr_q  <= i_solid_cr;
      end else if (stop) begin
        state  <= ST_IDLE;
      end

      if (emit) begin
        o_hdmi_v_sync     <= t_vs;
        o_hdmi_h_sync     <= t_hs;
        o_hdmi_data_valid <= t_dv;
        o_frame_done      <= t_fd;
        // data holds between valid beats
        if (t_dv) begin
          if (mode_eff == PG_RAMP) ramp_q <= ramp_nxt;
          o_hdmi_data_y  <= {N{pix_nxt.y}};
          o_hdmi_data_cb <= {N{pix_nxt.cb}};
          o_hdmi_data_cr <= {N{pix_nxt.cr}};
        end
      end else begin
        o_hdmi_v_sync     <= 1'b0;
        o_hdmi_h_sync     <= 1'b0;
        o_hdmi_data_valid <= 1'b0;
        o_frame_done      <= 1'b0;
        o_hdmi_data_y     <= '0;
        o_hdmi_data_cb    <= '0;
        o_hdmi_data_cr    <= '0;
      end
    end
  end

endmodule
